// File: rtl/cim_pkg.sv
// ============================================================================
//  Module      : cim_pkg
//  Description : Shared types and sizing helpers for the CIM fully-connected
//                layer (state encoding, tile count, accumulator width).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cim_pkg;

    // Layer controller states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CIM_WR   = 3'd1,
        ST_CIM_WAIT = 3'd2,
        ST_READ     = 3'd3,
        ST_OUT      = 3'd4
    } fc_state_t;

    // Number of crossbars needed to cover n items with xbar items each
    function automatic int tiles(input int n, input int xbar);
        return (n + xbar - 1) / xbar;
    endfunction

    // Accumulator width that cannot overflow when summing v signed dt-bit terms
    function automatic int acc_w(input int dt, input int v);
        return dt + $clog2(v) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fc_acc_sat.sv
// ============================================================================
//  Module      : fc_acc_sat
//  Description : Sums one partial sum per vertical tile at full width, applies
//                the optional ReLU (macro FC_RELU_EN), saturates to the signed
//                output width and registers the result on i_load.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_acc_sat
    import cim_pkg::*;
#(
    parameter int DATATYPE_SIZE        = 4,
    parameter int OUTPUT_DATATYPE_SIZE = 4,
    parameter int V_CIM_TILES          = 2,
    parameter int ACC_WIDTH            = acc_w(DATATYPE_SIZE, V_CIM_TILES)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_load,
    input  logic [V_CIM_TILES-1:0][DATATYPE_SIZE-1:0]   i_psum,
    output logic [OUTPUT_DATATYPE_SIZE-1:0]             o_data
);

    // Comparison width large enough for both the accumulator and the clamp limits
    localparam int c_ext_w = ((ACC_WIDTH > OUTPUT_DATATYPE_SIZE) ? ACC_WIDTH
                                                                 : OUTPUT_DATATYPE_SIZE) + 1;
    localparam logic signed [c_ext_w-1:0] c_sat_max = c_ext_w'((2 ** (OUTPUT_DATATYPE_SIZE - 1)) - 1);
    localparam logic signed [c_ext_w-1:0] c_sat_min = c_ext_w'(-(2 ** (OUTPUT_DATATYPE_SIZE - 1)));

    logic signed [ACC_WIDTH-1:0]            w_acc;
    logic signed [c_ext_w-1:0]              w_ext;
    logic [OUTPUT_DATATYPE_SIZE-1:0]        w_sat;
    logic [OUTPUT_DATATYPE_SIZE-1:0]        r_data;

    // Adder tree over vertical tiles, then activation and clamp
    always_comb begin
        w_acc = '0;
        for (int t = 0; t < V_CIM_TILES; t++) begin
            w_acc = w_acc + ACC_WIDTH'($signed(i_psum[t]));
        end
        w_ext = c_ext_w'(w_acc);
`ifdef FC_RELU_EN
        if (w_ext < 0) begin
            w_ext = '0;
        end
`endif
        if (w_ext > c_sat_max) begin
            w_sat = c_sat_max[OUTPUT_DATATYPE_SIZE-1:0];
        end else if (w_ext < c_sat_min) begin
            w_sat = c_sat_min[OUTPUT_DATATYPE_SIZE-1:0];
        end else begin
            w_sat = w_ext[OUTPUT_DATATYPE_SIZE-1:0];
        end
    end

    // Result register, loaded once per neuron
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= w_sat;
        end
    end

    assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/fc_layer_acc.sv
// ============================================================================
//  Module      : fc_layer_acc
//  Description : Fully-connected layer controller for CIM crossbars. Buffers
//                one input vector, streams it row by row into the tiles, reads
//                partial sums back, accumulates across vertical tiles and emits
//                one activated, saturated neuron per beat.
//                Optional ReLU selected by macro FC_RELU_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_layer_acc
    import cim_pkg::*;
#(
    parameter int DATATYPE_SIZE        = 4,
    parameter int OUTPUT_DATATYPE_SIZE = 4,
    parameter int XBAR_SIZE            = 512,
    parameter int INPUT_SIZE           = 720,
    parameter int OUTPUT_SIZE          = 70,
    parameter int V_CIM_TILES          = tiles(INPUT_SIZE, XBAR_SIZE),
    parameter int H_CIM_TILES          = tiles(OUTPUT_SIZE * DATATYPE_SIZE, XBAR_SIZE),
    parameter int OUTS_PER_TILE        = XBAR_SIZE / DATATYPE_SIZE,
    parameter int ACC_WIDTH            = acc_w(DATATYPE_SIZE, V_CIM_TILES)
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    i_ibuf_we,
    input  logic [$clog2(INPUT_SIZE)-1:0]                           i_ibuf_addr,
    input  logic [DATATYPE_SIZE-1:0]                                i_ibuf_wr_data,
    input  logic                                                    i_start,
    input  logic                                                    i_func_start,
    input  logic                                                    i_cim_busy,
    input  logic [V_CIM_TILES-1:0][H_CIM_TILES-1:0][DATATYPE_SIZE-1:0] i_data,
    input  logic                                                    i_next_busy,
    output logic                                                    o_busy,
    output logic                                                    o_cim_we,
    output logic [$clog2(XBAR_SIZE)-1:0]                            o_cim_wr_addr,
    output logic [V_CIM_TILES-1:0][DATATYPE_SIZE-1:0]               o_cim_data,
    output logic [$clog2(XBAR_SIZE)-1:0]                            o_cim_rd_addr,
    output logic                                                    o_func_valid,
    output logic [$clog2(OUTPUT_SIZE)-1:0]                          o_func_idx,
    output logic [OUTPUT_DATATYPE_SIZE-1:0]                         o_func_data
);

    localparam int c_row_w   = $clog2(XBAR_SIZE);
    localparam int c_idx_w   = $clog2(OUTPUT_SIZE);
    localparam int c_ibuf_aw = $clog2(INPUT_SIZE);
    localparam logic [c_row_w-1:0]   c_row_last    = c_row_w'(XBAR_SIZE - 1);
    localparam logic [c_idx_w-1:0]   c_neuron_last = c_idx_w'(OUTPUT_SIZE - 1);
    localparam logic [c_ibuf_aw-1:0] c_ibuf_last   = c_ibuf_aw'(INPUT_SIZE - 1);

    fc_state_t                                  r_state;
    fc_state_t                                  w_state_nxt;
    logic [c_row_w-1:0]                         r_row;
    logic [c_idx_w-1:0]                         r_neuron;
    logic [c_idx_w-1:0]                         w_rd_neuron;
    logic [DATATYPE_SIZE-1:0]                   r_ibuf [INPUT_SIZE];
    logic [V_CIM_TILES-1:0][DATATYPE_SIZE-1:0]  w_psum;
    logic [OUTPUT_DATATYPE_SIZE-1:0]            w_sat_data;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status/strobe outputs
    always_comb begin
        w_state_nxt   = r_state;
        o_busy        = (r_state != ST_IDLE);
        o_cim_we      = 1'b0;
        o_cim_wr_addr = r_row;
        o_func_valid  = 1'b0;
        o_func_idx    = '0;
        o_func_data   = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_CIM_WR;
                end
            end
            ST_CIM_WR: begin
                o_cim_we = !i_cim_busy;
                if (!i_cim_busy && r_row == c_row_last) begin
                    w_state_nxt = ST_CIM_WAIT;
                end
            end
            ST_CIM_WAIT: begin
                if (i_func_start) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                o_func_valid = 1'b1;
                o_func_idx   = r_neuron;
                o_func_data  = w_sat_data;
                if (!i_next_busy) begin
                    w_state_nxt = (r_neuron == c_neuron_last) ? ST_IDLE : ST_READ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Row and neuron counters; both return to 0 as their phase completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row    <= '0;
            r_neuron <= '0;
        end else begin
            if (r_state == ST_CIM_WR && !i_cim_busy) begin
                r_row <= (r_row == c_row_last) ? '0 : r_row + c_row_w'(1);
            end
            if (r_state == ST_OUT && !i_next_busy) begin
                r_neuron <= (r_neuron == c_neuron_last) ? '0 : r_neuron + c_idx_w'(1);
            end
        end
    end

    // Input buffer: writable only while idle, contents are not reset
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && i_ibuf_we && i_ibuf_addr <= c_ibuf_last) begin
            r_ibuf[i_ibuf_addr] <= i_ibuf_wr_data;
        end
    end

    // Row data per vertical tile; rows past the end of the vector are zero-padded
    always_comb begin
        o_cim_data = '0;
        for (int t = 0; t < V_CIM_TILES; t++) begin
            if (r_state == ST_CIM_WR && (t * XBAR_SIZE + int'(r_row)) < INPUT_SIZE) begin
                o_cim_data[t] = r_ibuf[c_ibuf_aw'(t * XBAR_SIZE + int'(r_row))];
            end
        end
    end

    // Read address runs one neuron ahead while a result is on the output, so the
    // tile data for the next neuron is already valid in its READ cycle
    always_comb begin
        w_rd_neuron = r_neuron;
        if (r_state == ST_OUT && r_neuron != c_neuron_last) begin
            w_rd_neuron = r_neuron + c_idx_w'(1);
        end
        o_cim_rd_addr = c_row_w'(32'(w_rd_neuron) % OUTS_PER_TILE);
    end

    generate
        if (H_CIM_TILES == 1) begin : g_hsel_single
            // Only one horizontal tile: take its partial sums directly
            always_comb begin
                w_psum = '0;
                for (int t = 0; t < V_CIM_TILES; t++) begin
                    w_psum[t] = i_data[t][0];
                end
            end
        end else begin : g_hsel_multi
            localparam int c_hsel_w = $clog2(H_CIM_TILES);
            logic [c_hsel_w-1:0] w_h_sel;
            // Pick the horizontal tile that holds the current neuron
            always_comb begin
                w_h_sel = c_hsel_w'(32'(r_neuron) / OUTS_PER_TILE);
                w_psum  = '0;
                for (int t = 0; t < V_CIM_TILES; t++) begin
                    w_psum[t] = i_data[t][w_h_sel];
                end
            end
        end
    endgenerate

    fc_acc_sat #(
        .DATATYPE_SIZE        (DATATYPE_SIZE),
        .OUTPUT_DATATYPE_SIZE (OUTPUT_DATATYPE_SIZE),
        .V_CIM_TILES          (V_CIM_TILES),
        .ACC_WIDTH            (ACC_WIDTH)
    ) u_acc_sat (
        .clk    (clk),
        .rst    (rst),
        .i_load (r_state == ST_READ),
        .i_psum (w_psum),
        .o_data (w_sat_data)
    );

endmodule

`default_nettype wire
